// File: rtl/ex_stage_pkg.sv
// Shared constants for the RV32I execute stage: ALU control codes, forward selects
// and branch funct3 encodings, plus the branch-condition helper.
package ex_stage_pkg;

   typedef enum logic [2:0] {
      ALU_CTL_ADD      = 3'b000,
      ALU_CTL_SUB      = 3'b001,
      ALU_CTL_AND      = 3'b010,
      ALU_CTL_OR       = 3'b011,
      ALU_CTL_LESS_SIG = 3'b100,
      ALU_CTL_LESS_UNS = 3'b101
   } alu_ctl_e;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Less-than branches rely on the decoder selecting a compare op, so bit 0 is the verdict.
   function automatic logic branch_cond(input logic [2:0] f3, input logic zero,
                                        input logic lsb);
      logic cond;
      case (f3)
         F3_BEQ:           cond = zero;
         F3_BNE:           cond = !zero;
         F3_BLT, F3_BLTU:  cond = lsb;
         F3_BGE, F3_BGEU:  cond = !lsb;
         default:          cond = 1'b0;
      endcase
      return cond;
   endfunction

endpackage

// File: rtl/ex_stage_alu_core.sv
// Combinational integer ALU shared between pipeline stages; wraps on overflow,
// exports no flags.
module alu_core
   import ex_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      ctl,
   output logic [XLEN-1:0] result
);

   logic signed [XLEN-1:0] a_s;
   logic signed [XLEN-1:0] b_s;
   logic                   lt_sig;
   logic                   lt_uns;

   assign a_s    = a;
   assign b_s    = b;
   assign lt_sig = a_s < b_s;
   assign lt_uns = a < b;

   always_comb begin
      result = '0;
      case (ctl)
         ALU_CTL_ADD:      result = a + b;
         ALU_CTL_SUB:      result = a - b;
         ALU_CTL_AND:      result = a & b;
         ALU_CTL_OR:       result = a | b;
         ALU_CTL_LESS_SIG: result = {{(XLEN-1){1'b0}}, lt_sig};
         ALU_CTL_LESS_UNS: result = {{(XLEN-1){1'b0}}, lt_uns};
         default:          result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the
// EX/MEM pipeline register with flush-over-stall priority.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall,
   input  logic            i_flush,
   input  logic            i_valid,
   input  logic [2:0]      i_alu_ctl,
   input  logic [2:0]      i_f3,
   input  logic            i_is_branch,
   input  logic            i_alu_src,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic [XLEN-1:0] i_imm,
   input  logic [1:0]      i_fwd_a,
   input  logic [1:0]      i_fwd_b,
   input  logic [XLEN-1:0] i_fwd_mem_data,
   input  logic [XLEN-1:0] i_fwd_wb_data,
   input  logic [4:0]      i_rd,
   input  logic            i_reg_write,
   input  logic            i_mem_read,
   input  logic            i_mem_write,
   output logic            o_valid,
   output logic [XLEN-1:0] o_alu_result,
   output logic [XLEN-1:0] o_store_data,
   output logic [4:0]      o_rd,
   output logic            o_reg_write,
   output logic            o_mem_read,
   output logic            o_mem_write,
   output logic            o_branch_taken,
   output logic [XLEN-1:0] o_branch_target
);

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] rs2_fwd;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_result;

   logic            valid_d,      valid_q;
   logic [XLEN-1:0] alu_result_d, alu_result_q;
   logic [XLEN-1:0] store_data_d, store_data_q;
   logic [4:0]      rd_d,         rd_q;
   logic            reg_write_d,  reg_write_q;
   logic            mem_read_d,   mem_read_q;
   logic            mem_write_d,  mem_write_q;

   // Select 11 falls back to the register file value, same as 00.
   always_comb begin
      op_a = i_rs1_data;
      case (i_fwd_a)
         FWD_MEM: op_a = i_fwd_mem_data;
         FWD_WB:  op_a = i_fwd_wb_data;
         default: op_a = i_rs1_data;
      endcase
      rs2_fwd = i_rs2_data;
      case (i_fwd_b)
         FWD_MEM: rs2_fwd = i_fwd_mem_data;
         FWD_WB:  rs2_fwd = i_fwd_wb_data;
         default: rs2_fwd = i_rs2_data;
      endcase
      op_b = i_alu_src ? i_imm : rs2_fwd;
   end

   alu_core #(.XLEN(XLEN)) u_alu (
      .a      (op_a),
      .b      (op_b),
      .ctl    (i_alu_ctl),
      .result (alu_result)
   );

   // Stall gating keeps the redirect to a single pulse while the branch sits in EX.
   assign o_branch_taken  = i_valid & i_is_branch & !i_stall &
                            branch_cond(i_f3, alu_result == '0, alu_result[0]);
   assign o_branch_target = i_pc + i_imm;

   always_comb begin
      valid_d      = valid_q;
      alu_result_d = alu_result_q;
      store_data_d = store_data_q;
      rd_d         = rd_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      if (i_flush || !i_stall) begin
         alu_result_d = alu_result;
         store_data_d = rs2_fwd;
         rd_d         = i_rd;
         valid_d      = i_valid & !i_flush;
         reg_write_d  = i_reg_write & i_valid & !i_flush;
         mem_read_d   = i_mem_read  & i_valid & !i_flush;
         mem_write_d  = i_mem_write & i_valid & !i_flush;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q      <= 1'b0;
         alu_result_q <= '0;
         store_data_q <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         valid_q      <= valid_d;
         alu_result_q <= alu_result_d;
         store_data_q <= store_data_d;
         rd_q         <= rd_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
      end
   end

   assign o_valid      = valid_q;
   assign o_alu_result = alu_result_q;
   assign o_store_data = store_data_q;
   assign o_rd         = rd_q;
   assign o_reg_write  = reg_write_q;
   assign o_mem_read   = mem_read_q;
   assign o_mem_write  = mem_write_q;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline.
- Consumes the 3-bit ALU control code from the ALU control decoder and the ID/EX operands.
- Applies forwarding, computes the ALU result, and resolves branches.
- Registers everything into the EX/MEM pipeline register, with stall/flush handling and a valid bit.

Parameters:
- XLEN, 32, datapath width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  hold EX/MEM register (downstream stall)
- i_flush  in  1  invalidate instruction entering EX/MEM
- i_valid  in  1  ID/EX slot holds a real instruction
- i_alu_ctl  in  3  ALU operation code from the decoder
- i_f3  in  3  funct3, used for branch condition
- i_is_branch  in  1  instruction is a conditional branch
- i_alu_src  in  1  0: operand B = forwarded rs2; 1: operand B = i_imm
- i_pc  in  XLEN  PC of the instruction
- i_rs1_data, i_rs2_data, i_imm  in  XLEN each  ID/EX operands
- i_fwd_a, i_fwd_b  in  2 each  forward select: 00 reg, 01 MEM, 10 WB, 11 reg
- i_fwd_mem_data, i_fwd_wb_data  in  XLEN each  forwarded values
- i_rd  in  5  destination register
- i_reg_write, i_mem_read, i_mem_write  in  1 each  control bits passed through
- o_valid  out  1  EX/MEM valid
- o_alu_result  out  XLEN  registered ALU result
- o_store_data  out  XLEN  registered forwarded rs2
- o_rd  out  5  registered destination register
- o_reg_write, o_mem_read, o_mem_write  out  1 each  registered, gated by valid
- o_branch_taken  out  1  combinational redirect
- o_branch_target  out  XLEN  combinational i_pc + i_imm

Behaviour:
- Reset (i_rst_n low, asynchronous): every registered output is 0. Combinational outputs follow their inputs.
- Operand A is the i_fwd_a selection of i_rs1_data, MEM data or WB data.
- Forwarded rs2 is the i_fwd_b selection; operand B is that value or i_imm per i_alu_src.
- ALU, all results XLEN wide, wrap-around on overflow, no flags exported:
  - ADD: A+B
  - SUB: A-B
  - AND: A&B
  - OR: A|B
  - LESS_SIG: {0…, $signed(A)<$signed(B)}
  - LESS_UNS: {0…, A<B}
  - codes 6 and 7: result 0
- Branch resolution:
  - zero = (result==0)
  - f3 000 beq: taken = zero
  - f3 001 bne: taken = !zero
  - f3 100 blt and 110 bltu: taken = result[0]
  - f3 101 bge and 111 bgeu: taken = !result[0]
  - f3 010 and 011: not taken
- o_branch_taken = i_valid & i_is_branch & !i_stall & cond.
  - Gating with !i_stall guarantees a single redirect pulse per branch.
- EX/MEM register update, in priority order:
  1. i_flush: o_valid and all three control outputs go to 0; data outputs are don't-care, implementation loads them.
  2. i_stall: all outputs hold.
  3. Otherwise: load all outputs; o_valid = i_valid; control outputs = input & i_valid.
- Flush and stall in the same cycle: flush wins.
- Latency: exactly one cycle from ID/EX inputs to EX/MEM outputs.
- Branch outputs are zero-latency.
- A branch does not write a register; i_reg_write from the decoder is 0 for branches and is passed as given.
- Reset mid-stall: the register clears immediately; the first load after release follows the normal priority rules.

Decomposition:
- Constants.vh holds the shared constants:
  - ALU_CTL_ADD=3'b000, ALU_CTL_SUB=3'b001, ALU_CTL_AND=3'b010, ALU_CTL_OR=3'b011, ALU_CTL_LESS_SIG=3'b100, ALU_CTL_LESS_UNS=3'b101
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - F3 branch encodings
- One combinational sub-module, alu_core (inputs A, B, ctl; output result), reusable by other stages.
- Forwarding muxes, branch logic and the EX/MEM register stay in ex_stage.

Test Plan:
- ALU sweep, i_valid=1, no stall or flush, A=0xFFFFFFFE, B=0x00000003 -> next-cycle o_alu_result:
  - ADD 0x00000001, SUB 0xFFFFFFFB, AND 0x00000002, OR 0xFFFFFFFF
  - LESS_SIG 1, LESS_UNS 0
- Forwarding:
  - rs1=5, MEM=7, WB=9, i_fwd_a=01, ADD, B=imm 1, i_alu_src=1 -> o_alu_result=8.
  - i_fwd_b=10, i_alu_src=0 -> o_store_data=9.
- Branches, pc=0x100, imm=0x20 -> o_branch_target=0x120 in every case:
  - bne 3 vs 3 -> taken 0
  - bltu with decoder code LESS_UNS, 1 vs 0xFFFFFFFF -> taken 1
  - bge with code LESS_SIG, -1 vs 0 -> taken 0
  - i_stall=1 with any taken branch -> taken 0
- Stall then flush:
  - Load rd=3 with reg_write=1, then stall 2 cycles with changing inputs -> outputs unchanged.
  - Assert i_flush and i_stall together -> o_valid=0, o_reg_write=0 next cycle.
- Bubble: i_valid=0 with i_reg_write=1, i_mem_write=1 -> o_valid=0, o_reg_write=0, o_mem_write=0.
- Async reset: assert i_rst_n=0 mid-cycle while outputs are nonzero -> all registered outputs 0 before the next clock edge; release, then a valid ADD 2+2 gives o_alu_result=4 one cycle later.
